// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and the data memory.
// One word request at a time; registered memory controls and a registered dbus drive enable.
module dmem_access_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] dbus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic              drive_q;
  logic              err_d;
  logic              accept;
  logic              oor;

  assign accept = req_valid & req_ready & (state_q == IDLE);
  assign oor    = req_addr >= ADDR_W'(MEM_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = mem_addr;
    wdata_d = wdata_q;
    rdata_d = resp_rdata;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          wdata_d = req_wdata;
          if (oor) begin
            // mem_addr keeps its last value; the memory is never touched
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            addr_d  = req_addr;
            state_d = req_we ? WRITE : READ;
          end
        end
      end
      WRITE: state_d = RESP;
      READ: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(READ_LAT)) begin
          rdata_d = dbus;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      req_ready  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      mem_addr   <= addr_d;
      req_ready  <= (state_d == IDLE);
      mem_en     <= (state_d == WRITE) || (state_d == READ);
      mem_we     <= (state_d == WRITE);
      drive_q    <= (state_d == WRITE);
      resp_valid <= (state_d == RESP);
      resp_err   <= err_d;
      resp_rdata <= rdata_d;
    end
  end

  assign dbus = drive_q ? wdata_q : 'z;

endmodule
